// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampling 8N1 receiver that hunts A5 5A sync and publishes
// checksum-verified 64-byte cube frames.
module uart_frame_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         rx,
  output logic [511:0] frame_cube_flat,
  output logic         frame_valid,
  output logic         chk_err,
  output logic [7:0]   err_cnt
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  localparam int CW   = $clog2(CPB);
  localparam int TW   = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_e;
  typedef enum logic [1:0] {SYNC0, SYNC1, PAYLOAD, CHECK} frm_st_e;

  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  bit_st_e        bst_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  frm_st_e        fst_q;
  logic [5:0]     idx_q;
  logic [7:0]     sum_q;
  logic [511:0]   shadow_q, frame_q;
  logic [TW-1:0]  tmo_q;
  logic           valid_q, err_q;
  logic [7:0]     err_cnt_q;
  logic           fall, sample, byte_done, frm_err, tmo_hit, bad_sum, err_d;

  assign fall      = rx_prev_q & ~rx_s2_q;
  assign sample    = cnt_q == CW'(bst_q == START ? HALF - 1 : CPB - 1);
  assign byte_done = en && bst_q == STOP && sample && rx_s2_q;
  assign frm_err   = en && bst_q == STOP && sample && !rx_s2_q;
  assign tmo_hit   = en && fst_q != SYNC0 && tmo_q == TW'(TMO - 1);
  assign bad_sum   = byte_done && fst_q == CHECK && shift_q != sum_q;
  // a coincident framing error and timeout collapse into one pulse here
  assign err_d     = frm_err | tmo_hit | bad_sum;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      bst_q     <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      cnt_q     <= (bst_q == IDLE || sample) ? '0 : cnt_q + CW'(1);
      if (!en) bst_q <= IDLE;
      else
        case (bst_q)
          IDLE:  if (fall) bst_q <= START;
          START: if (sample) begin
            bst_q     <= rx_s2_q ? IDLE : DATA;
            bit_idx_q <= '0;
          end
          DATA:  if (sample) begin
            shift_q   <= {rx_s2_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) bst_q <= STOP;
          end
          default: if (sample) bst_q <= IDLE;
        endcase
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fst_q     <= SYNC0;
      idx_q     <= '0;
      sum_q     <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= err_d;
      if (err_d) err_cnt_q <= err_cnt_q + {7'd0, err_cnt_q != 8'hFF};
      tmo_q <= (!en || fst_q == SYNC0 || byte_done) ? '0 : tmo_q + TW'(1);
      if (!en || err_d) fst_q <= SYNC0;
      else if (byte_done)
        case (fst_q)
          SYNC0: fst_q <= shift_q == 8'hA5 ? SYNC1 : SYNC0;
          SYNC1: begin
            fst_q <= shift_q == 8'h5A ? PAYLOAD : shift_q == 8'hA5 ? SYNC1 : SYNC0;
            idx_q <= '0;
            sum_q <= '0;
          end
          PAYLOAD: begin
            shadow_q[{idx_q, 3'b000} +: 8] <= shift_q;
            sum_q <= sum_q + shift_q;
            idx_q <= idx_q + 6'd1;
            if (idx_q == 6'd63) fst_q <= CHECK;
          end
          default: begin
            frame_q <= shadow_q;
            valid_q <= 1'b1;
            fst_q   <= SYNC0;
          end
        endcase
    end

  assign frame_cube_flat = frame_q;
  assign frame_valid     = valid_q;
  assign chk_err         = err_q;
  assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed + randomized frame traffic checked against a byte-level
// model of sync/checksum rules and an expected error tally.
module tb_uart_frame_rx;
  localparam int CPB = 4;
  localparam int TMO = 32 * CPB;

  logic         clk = 1'b0, resetn = 1'b0, en = 1'b1, rx = 1'b1;
  logic [511:0] frame_cube_flat;
  logic         frame_valid, chk_err;
  logic [7:0]   err_cnt;

  int checks = 0, failures = 0;
  int n_valid = 0, n_err = 0, exp_err = 0, v0 = 0, e0 = 0;
  logic [7:0]   pay [64];
  logic [511:0] exp_frame = '0;

  uart_frame_rx #(.CLK_FREQ(400), .BAUD(100), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .resetn(resetn), .en(en), .rx(rx),
    .frame_cube_flat(frame_cube_flat), .frame_valid(frame_valid),
    .chk_err(chk_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (chk_err) n_err++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (pay[i]) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  function automatic logic [511:0] model_frame();
    logic [511:0] f = '0;
    foreach (pay[i]) f[8*i +: 8] = pay[i];
    return f;
  endfunction

  function automatic int exp_cnt();
    return exp_err > 255 ? 255 : exp_err;
  endfunction

  task automatic chk_f(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    if (!stop) begin
      rx = 1'b1;
      idle(CPB);
    end
  endtask

  task automatic send_head(input int n);
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < n; i++) send_byte(pay[i]);
  endtask

  task automatic send_frame(input logic [7:0] ck);
    send_head(64);
    send_byte(ck);
  endtask

  task automatic randomize_pay();
    foreach (pay[i]) pay[i] = 8'($urandom);
  endtask

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  task automatic expect_good(input string tag);
    idle(4 * CPB);
    exp_frame = model_frame();
    chk_n({tag, "_valid"}, n_valid - v0, 1);
    chk_n({tag, "_err"}, n_err - e0, 0);
    chk_f({tag, "_frame"}, frame_cube_flat, exp_frame);
    chk_n({tag, "_cnt"}, int'(err_cnt), exp_cnt());
  endtask

  task automatic expect_quiet(input string tag, input int errs);
    idle(2 * CPB);
    exp_err += errs;
    chk_n({tag, "_valid"}, n_valid - v0, 0);
    chk_n({tag, "_err"}, n_err - e0, errs);
    chk_f({tag, "_held"}, frame_cube_flat, exp_frame);
    chk_n({tag, "_cnt"}, int'(err_cnt), exp_cnt());
  endtask

  initial begin
    idle(3);
    chk_f("rst_frame", frame_cube_flat, '0);
    chk_n("rst_valid", int'(frame_valid), 0);
    chk_n("rst_err", int'(chk_err), 0);
    chk_n("rst_cnt", int'(err_cnt), 0);
    resetn = 1'b1;
    idle(4);

    foreach (pay[i]) pay[i] = 8'(i);
    mark();
    send_frame(model_sum());
    expect_good("inc");
    chk_n("inc_lo", int'(frame_cube_flat[7:0]), 'h00);
    chk_n("inc_hi", int'(frame_cube_flat[511:504]), 'h3F);

    randomize_pay();
    mark();
    send_frame(model_sum());
    expect_good("rnd");

    foreach (pay[i]) pay[i] = 8'(i);
    mark();
    send_frame(model_sum() + 8'd1);
    expect_quiet("badsum", 1);

    foreach (pay[i]) pay[i] = 8'hFF;
    mark();
    send_byte(8'h00);
    send_byte(8'hA5);
    send_frame(model_sum());
    expect_good("resync");
    chk_f("resync_ones", frame_cube_flat, {512{1'b1}});

    mark();
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(3 * CPB);
    expect_quiet("glitch", 0);

    randomize_pay();
    mark();
    send_head(5);
    send_byte(8'h3C, 1'b0);
    expect_quiet("framing", 1);
    randomize_pay();
    mark();
    send_frame(model_sum());
    expect_good("after_framing");

    randomize_pay();
    mark();
    send_head(10);
    idle(TMO - 16);
    chk_n("tmo_early", n_err - e0, 0);
    idle(32);
    expect_quiet("timeout", 1);
    randomize_pay();
    mark();
    send_frame(model_sum());
    expect_good("after_tmo");

    randomize_pay();
    mark();
    send_head(7);
    fork
      send_byte(pay[7]);
      begin
        idle(3 * CPB);
        en = 1'b0;
      end
    join
    for (int i = 8; i < 20; i++) send_byte(pay[i]);
    expect_quiet("en_off", 0);
    en = 1'b1;
    idle(CPB);
    randomize_pay();
    mark();
    send_frame(model_sum());
    expect_good("en_back");

    mark();
    for (int i = 0; i < 256; i++) send_byte(8'h00, 1'b0);
    expect_quiet("saturate", 256);
    chk_n("sat_ff", int'(err_cnt), 255);

    randomize_pay();
    send_head(5);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    exp_err = 0;
    exp_frame = '0;
    chk_f("mid_rst_frame", frame_cube_flat, exp_frame);
    chk_n("mid_rst_valid", int'(frame_valid), 0);
    chk_n("mid_rst_err", int'(chk_err), 0);
    chk_n("mid_rst_cnt", int'(err_cnt), exp_cnt());
    idle(2);
    resetn = 1'b1;
    idle(CPB);
    randomize_pay();
    mark();
    send_frame(model_sum());
    expect_good("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
